// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART TX block: register offsets, STATUS/CTRL bit
// positions and TX state encodings.
package uart_tx_pkg;

  localparam logic [4:0] REG_CTRL   = 5'h00;
  localparam logic [4:0] REG_DATA   = 5'h08;
  localparam logic [4:0] REG_DIV    = 5'h0C;
  localparam logic [4:0] REG_STATUS = 5'h10;

  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_PARITY_EN = 1;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_LEVEL_LSB = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Only address bits [4:2] are decoded, so registers are compared by word index.
  function automatic logic [2:0] word_index(input logic [4:0] offset);
    return offset[4:2];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with an extra pointer MSB to tell full from
// empty. Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo_ip.sv
// Memory-mapped UART transmitter with TX FIFO, run-time baud divisor and status.
// Define UARTTX_PARITY_EN to add CTRL.parity_en and an even-parity bit per frame.
module uart_tx_fifo_ip
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 12_000_000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int FIFO_DEPTH   = 16,
  parameter int DIV_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        tx,
  output logic        irq_txempty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(CLK_FREQ_HZ / DEFAULT_BAUD - 1);

  logic [2:0]       word;
  logic             wr;
  logic             rd;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [AW:0]      level;
  logic [7:0]       head;
  logic             tx_en;
  logic             parity_en;
  logic [DIV_W-1:0] div;
  logic             overflow;
  logic [2:0]       state;
  logic [DIV_W-1:0] baud_cnt;
  logic             baud_done;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             busy;
  logic             start_frame;
  logic [31:0]      read_word;
  logic             unused_bits;

  assign word      = bus_addr[4:2];
  assign wr        = bus_valid && bus_we;
  assign rd        = bus_valid && !bus_we;
  assign push      = wr && (word == word_index(REG_DATA));
  assign busy      = (state != ST_IDLE);
  assign baud_done = (baud_cnt == '0);
  // A new frame may begin straight out of the last stop-bit clock, so queued
  // bytes go out back to back.
  assign start_frame = tx_en && !empty &&
                       ((state == ST_IDLE) || ((state == ST_STOP) && baud_done));
  assign pop         = start_frame;
  assign unused_bits = ^{bus_addr, bus_wdata, level};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus_wdata[7:0]),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_en    <= 1'b1;
      div      <= RESET_DIV;
      overflow <= 1'b0;
    end else begin
      if (wr && (word == word_index(REG_CTRL))) tx_en <= bus_wdata[CTRL_TX_EN];
      if (wr && (word == word_index(REG_DIV)))
        div <= (bus_wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : bus_wdata[DIV_W-1:0];
      // Full is judged before any same-cycle pop, so such a push is still lost.
      if (push && full)
        overflow <= 1'b1;
      else if (wr && (word == word_index(REG_STATUS)) && bus_wdata[STAT_OVERFLOW])
        overflow <= 1'b0;
    end
  end

`ifdef UARTTX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_en <= 1'b0;
    else if (wr && (word == word_index(REG_CTRL))) parity_en <= bus_wdata[CTRL_PARITY_EN];
  end
`else
  assign parity_en = 1'b0;
`endif

  always_comb begin
    read_word = '0;
    case (word)
      word_index(REG_CTRL): begin
        read_word[CTRL_TX_EN]     = tx_en;
        read_word[CTRL_PARITY_EN] = parity_en;
      end
      word_index(REG_DIV): read_word = 32'(div);
      word_index(REG_STATUS): begin
        read_word[STAT_BUSY]                         = busy;
        read_word[STAT_FULL]                         = full;
        read_word[STAT_EMPTY]                        = empty;
        read_word[STAT_OVERFLOW]                     = overflow;
        read_word[STAT_LEVEL_LSB+7:STAT_LEVEL_LSB]   = 8'(level);
      end
      default: read_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_rdata   <= '0;
      irq_txempty <= 1'b1;
    end else begin
      if (rd) bus_rdata <= read_word;
      irq_txempty <= empty && !busy;
    end
  end

  // The baud counter reloads from div only at bit boundaries, so a divisor
  // write never stretches or cuts the bit currently on the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UARTTX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (state != ST_IDLE) baud_cnt <= baud_done ? div : baud_cnt - 1'b1;
      case (state)
        ST_IDLE: ;
        ST_START:
          if (baud_done) begin
            state   <= ST_DATA;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= '0;
          end
        ST_DATA:
          if (baud_done) begin
            if (bit_cnt == 3'd7) begin
`ifdef UARTTX_PARITY_EN
              if (parity_en) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
`else
              state <= ST_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
`ifdef UARTTX_PARITY_EN
        ST_PARITY:
          if (baud_done) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
`endif
        ST_STOP:
          if (baud_done) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (start_frame) begin
        state    <= ST_START;
        tx       <= 1'b0;
        baud_cnt <= div;
        shreg    <= head;
`ifdef UARTTX_PARITY_EN
        par_bit  <= ^head;
`endif
      end
    end
  end

endmodule
